// File: rtl/btn_cond_pkg.sv
// Shared constants and types for the push-button conditioner.
// The defaults give a 10 ms debounce window at 125 MHz.
package btn_cond_pkg;

    localparam int STABLE_CNT_DEFAULT = 1_250_000;
    localparam int CNT_W_DEFAULT      = 21;

    // Per-channel debounce state; it is derived from s2 versus level and exists to make waveforms readable.
    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } db_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One conditioner channel: a 2-flop synchroniser, a stability counter, the accepted level,
// and one-cycle press/release pulses that are registered with the level change.
module debounce_channel
    import btn_cond_pkg::*;
#(
    parameter int STABLE_CNT = STABLE_CNT_DEFAULT,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic level,
    output logic press,
    output logic release_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             level_next;
    logic             press_next;
    logic             release_next;
    db_state_e        state;

    // NOTE: Every signal gets its default value first, so no path through this block leaves a latch behind.
    always_comb begin
        state        = (s2 == level) ? STABLE : PENDING;
        cnt_next     = '0;
        level_next   = level;
        press_next   = 1'b0;
        release_next = 1'b0;
        case (state)
            STABLE: ;
            PENDING: begin
                if (cnt == CNT_LAST) begin
                    level_next   = s2;
                    press_next   = s2;
                    release_next = ~s2;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // NOTE: Non-blocking assignments make s1 and s2 act as a true two-stage shift, which a blocking chain would not.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1            <= 1'b0;
            s2            <= 1'b0;
            cnt           <= '0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            s1            <= raw_in;
            s2            <= s1;
            cnt           <= cnt_next;
            level         <= level_next;
            press         <= press_next;
            release_pulse <= release_next;
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel button/switch conditioner. It runs one independent debounce_channel per input
// and produces clean levels plus single-cycle press/release pulses.
module btn_conditioner
    import btn_cond_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int STABLE_CNT = STABLE_CNT_DEFAULT,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_pulse
);

    // The counter has to reach STABLE_CNT-1 without wrapping, and the accept needs at least one counting cycle.
    if (STABLE_CNT < 2 || longint'(STABLE_CNT) >= (longint'(1) << CNT_W)) begin : g_bad_param
        $error("btn_conditioner: STABLE_CNT=%0d is outside 2..2**CNT_W-1 (CNT_W=%0d)",
               STABLE_CNT, CNT_W);
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        debounce_channel #(
            .STABLE_CNT (STABLE_CNT),
            .CNT_W      (CNT_W)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .raw_in        (raw_in[ch]),
            .level         (level[ch]),
            .press         (press[ch]),
            .release_pulse (release_pulse[ch])
        );
    end

endmodule
